// File: rtl/multi_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module   : multi_ctrl_ws
// Purpose  : Multicycle MIPS control FSM with mem_req/mem_ready wait states,
//            a bus timeout and an optional extended ISA (MULTI_CTRL_EXT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module multi_ctrl_ws #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       lbu,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic       bus_err,
    output logic [4:0] state
);

`ifdef MULTI_CTRL_EXT_EN
    localparam logic EXT_EN = 1'b1;
`else
    localparam logic EXT_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_MEMADR  = 5'd2,
        S_MEMRD   = 5'd3,
        S_MEMWB   = 5'd4,
        S_MEMWR   = 5'd5,
        S_EXECUTE = 5'd6,
        S_ALUWB   = 5'd7,
        S_BRANCH  = 5'd8,
        S_IEXEC   = 5'd9,
        S_IWB     = 5'd10,
        S_JUMP    = 5'd11,
        S_ERROR   = 5'd12
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_err_q, bus_err_d;

    logic op_load, op_store, op_rtype, op_branch, op_imm, op_jump, op_legal;
    logic is_lbu, is_bne;
    logic timeout_hit;

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        logic [3:0] a;
        a = ALU_ADD;
        case (f)
            6'b100000: a = ALU_ADD;
            6'b100010: a = ALU_SUB;
            6'b100100: a = ALU_AND;
            6'b100101: a = ALU_OR;
            6'b100110: a = EXT_EN ? ALU_XOR : ALU_ADD;
            6'b101010: a = ALU_SLT;
            6'b000110: a = EXT_EN ? ALU_SRLV : ALU_ADD;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

    always_comb begin
        is_lbu    = EXT_EN && (op == OP_LBU);
        is_bne    = EXT_EN && (op == OP_BNE);
        op_load   = (op == OP_LW) || is_lbu;
        op_store  = (op == OP_SW);
        op_rtype  = (op == OP_RTYPE);
        op_branch = (op == OP_BEQ) || is_bne;
        op_imm    = (op == OP_ADDI) ||
                    (EXT_EN && ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI)));
        op_jump   = (op == OP_J);
        op_legal  = op_load || op_store || op_rtype || op_branch || op_imm || op_jump;
    end

    // Timeout fires on the (MAX_WAIT+1)th consecutive not-ready cycle.
    assign timeout_hit = (MAX_WAIT != 0) && (wait_q == MAX_WAIT_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    case (state_q)
                        S_FETCH: state_d = S_DECODE;
                        S_MEMRD: state_d = S_MEMWB;
                        default: state_d = S_FETCH;
                    endcase
                end else if (timeout_hit) begin
                    state_d   = S_ERROR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (op_load || op_store) state_d = S_MEMADR;
                else if (op_rtype)       state_d = S_EXECUTE;
                else if (op_branch)      state_d = S_BRANCH;
                else if (op_imm)         state_d = S_IEXEC;
                else if (op_jump)        state_d = S_JUMP;
                else                     state_d = S_FETCH;
            end
            S_MEMADR:  state_d = op_store ? S_MEMWR : S_MEMRD;
            S_EXECUTE: state_d = S_ALUWB;
            S_IEXEC:   state_d = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        lbu        = 1'b0;
        alusrcb    = 3'b000;
        pcsrc      = 2'b00;
        alucontrol = 4'b0000;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = 3'b001;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready;
                pcen       = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = 3'b011;
                alucontrol = ALU_ADD;
                illegal    = !op_legal;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b010;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                lbu     = is_lbu;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                lbu      = is_lbu;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu(funct);
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = is_bne ? !zero : zero;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                if (op == OP_ADDI) begin
                    alusrcb    = 3'b010;
                    alucontrol = ALU_ADD;
                end else begin
                    alusrcb = 3'b100;
                    case (op)
                        OP_ANDI: alucontrol = ALU_AND;
                        OP_ORI:  alucontrol = ALU_OR;
                        default: alucontrol = ALU_XOR;
                    endcase
                end
            end
            S_IWB:   regwrite = 1'b1;
            S_JUMP: begin
                pcen  = 1'b1;
                pcsrc = 2'b10;
            end
            default: ;
        endcase
        // Reset forces a quiet, fetch-like output vector regardless of inputs.
        if (reset) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            pcen       = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            iord       = 1'b0;
            memtoreg   = 1'b0;
            regdst     = 1'b0;
            lbu        = 1'b0;
            alusrcb    = 3'b001;
            pcsrc      = 2'b00;
            alucontrol = ALU_ADD;
            illegal    = 1'b0;
        end
    end

    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_ctrl_ws
// Purpose  : Self-checking bench for multi_ctrl_ws against an instruction-level
//            reference model; honours MULTI_CTRL_EXT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_ctrl_ws;

`ifdef MULTI_CTRL_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif
    localparam int MAXW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, memwrite, pcen, irwrite, regwrite, alusrca, iord;
    logic       memtoreg, regdst, lbu, illegal, bus_err;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic [4:0] state;
    logic [25:0] act;

    int total = 0;
    int bad   = 0;

    multi_ctrl_ws #(.WAIT_W(4), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .lbu(lbu),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, memwrite, pcen, irwrite, regwrite, alusrca, iord,
                  memtoreg, regdst, lbu, alusrcb, pcsrc, alucontrol, illegal,
                  bus_err, state};

    function automatic bit is_legal(input logic [5:0] o);
        case (o)
            6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100011, 6'b101011: return 1'b1;
            6'b000101, 6'b001100, 6'b001101, 6'b001110, 6'b100100: return EXT;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b1010;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100110: return EXT ? 4'b0011 : 4'b0010;
            6'b101010: return 4'b1011;
            6'b000110: return EXT ? 4'b0100 : 4'b0010;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expected output vector for a given architectural step of an instruction.
    function automatic logic [25:0] exp_vec(input int st, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input logic r, input logic rs);
        logic mr, mw, pe, ir, rw, asa, io, mtr, rd, lb, il, be;
        logic [2:0] asb;
        logic [1:0] ps;
        logic [3:0] ac;
        logic [4:0] s5;
        {mr, mw, pe, ir, rw, asa, io, mtr, rd, lb, il, be} = '0;
        asb = 3'b000; ps = 2'b00; ac = 4'b0000; s5 = st[4:0];
        if (rs) begin
            asb = 3'b001; ac = 4'b0010; s5 = 5'd0;
        end else begin
            case (st)
                0:  begin mr = 1; asb = 3'b001; ac = 4'b0010; ir = r; pe = r; end
                1:  begin asb = 3'b011; ac = 4'b0010; il = !is_legal(o); end
                2:  begin asa = 1; asb = 3'b010; ac = 4'b0010; end
                3:  begin mr = 1; io = 1; lb = EXT && (o == 6'b100100); end
                4:  begin rw = 1; mtr = 1; lb = EXT && (o == 6'b100100); end
                5:  begin mr = 1; mw = 1; io = 1; end
                6:  begin asa = 1; ac = alu_of(f); end
                7:  begin rw = 1; rd = 1; end
                8:  begin asa = 1; ac = 4'b1010; ps = 2'b01;
                          pe = (o == 6'b000101) ? !z : z; end
                9:  begin
                        asa = 1;
                        case (o)
                            6'b001100: begin asb = 3'b100; ac = 4'b0000; end
                            6'b001101: begin asb = 3'b100; ac = 4'b0001; end
                            6'b001110: begin asb = 3'b100; ac = 4'b0011; end
                            default:   begin asb = 3'b010; ac = 4'b0010; end
                        endcase
                    end
                10: rw = 1;
                11: begin pe = 1; ps = 2'b10; end
                12: be = 1;
                default: ;
            endcase
        end
        return {mr, mw, pe, ir, rw, asa, io, mtr, rd, lb, asb, ps, ac, il, be, s5};
    endfunction

    // Runs one instruction from FETCH; wf/wm = not-ready cycles in fetch / data
    // access (-1 picks a random count that stays within the timeout).
    task automatic exec_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input int wf, input int wm);
        int p[5];
        int n;
        int w;
        logic r;
        logic [25:0] e;
        p = '{0, 1, 0, 0, 0};
        n = 2;
        if (is_legal(o)) begin
            case (o)
                6'b100011, 6'b100100: begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
                6'b101011:            begin p[2] = 2; p[3] = 5; n = 4; end
                6'b000000:            begin p[2] = 6; p[3] = 7; n = 4; end
                6'b000100, 6'b000101: begin p[2] = 8; n = 3; end
                6'b000010:            begin p[2] = 11; n = 3; end
                default:              begin p[2] = 9; p[3] = 10; n = 4; end
            endcase
        end
        op = o; funct = f; zero = z;
        for (int i = 0; i < n; i++) begin
            w = (p[i] == 0) ? wf : ((p[i] == 3 || p[i] == 5) ? wm : 0);
            if (w < 0) w = $urandom_range(0, MAXW);
            for (int k = 0; k <= w; k++) begin
                if (p[i] == 0 || p[i] == 3 || p[i] == 5) r = (k == w);
                else r = 1'($urandom);
                mem_ready = r;
                e = exp_vec(p[i], o, f, z, r, 1'b0);
                @(negedge clk);
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s op=%b step=%0d wait=%0d act=%h exp=%h", nm, o, i, k, act, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            total++;
            if (act !== exp_vec(0, op, funct, zero, 1'b1, 1'b1)) begin
                bad++;
                $display("FAIL reset_vector act=%h exp=%h", act, exp_vec(0, op, funct, zero, 1'b1, 1'b1));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        exec_instr("rtype_add", 6'b000000, 6'b100000, 1'b0, 0, 0);
        exec_instr("rtype_sub", 6'b000000, 6'b100010, 1'b1, 0, 0);
        exec_instr("rtype_xor", 6'b000000, 6'b100110, 1'b0, 0, 0);
        exec_instr("rtype_bad_funct", 6'b000000, 6'b111111, 1'b0, 1, 0);
    endtask

    task automatic test_lw_wait();
        exec_instr("lw_wait3", 6'b100011, 6'b000000, 1'b0, 0, 3);
        exec_instr("sw_wait2", 6'b101011, 6'b000000, 1'b0, 2, 2);
        exec_instr("lbu", 6'b100100, 6'b000000, 1'b0, 0, 1);
    endtask

    task automatic test_branch_jump();
        exec_instr("bne_z0", 6'b000101, 6'b000000, 1'b0, 0, 0);
        exec_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 0, 0);
        exec_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 0, 0);
        exec_instr("jump", 6'b000010, 6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_imm_illegal();
        exec_instr("ori", 6'b001101, 6'b000000, 1'b0, 0, 0);
        exec_instr("addi", 6'b001000, 6'b000000, 1'b0, 0, 0);
        exec_instr("illegal_3f", 6'b111111, 6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_timeout();
        logic [25:0] e;
        op = 6'b000000; funct = 6'b100000;
        for (int k = 0; k < MAXW + 1; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            total++;
            e = exp_vec(0, op, funct, zero, 1'b0, 1'b0);
            if (act !== e) begin
                bad++;
                $display("FAIL timeout_fetch_wait k=%0d act=%h exp=%h", k, act, e);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            total++;
            e = exp_vec(12, op, funct, zero, mem_ready, 1'b0);
            if (act !== e) begin
                bad++;
                $display("FAIL timeout_error_hold k=%0d act=%h exp=%h", k, act, e);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++;
        e = exp_vec(0, op, funct, zero, 1'b0, 1'b0);
        if (act !== e) begin
            bad++;
            $display("FAIL timeout_reset_recover act=%h exp=%h", act, e);
        end
        @(posedge clk); #1;
        exec_instr("after_timeout", 6'b000000, 6'b100101, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_access();
        logic [25:0] e;
        exec_instr("pre_mid", 6'b001000, 6'b000000, 1'b0, 0, 0);
        op = 6'b100011;
        mem_ready = 1'b1; @(posedge clk); #1;   // FETCH
        @(posedge clk); #1;                     // DECODE
        @(posedge clk); #1;                     // MEMADR -> MEMRD
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        e = exp_vec(3, op, funct, zero, 1'b0, 1'b0);
        if (act !== e) begin
            bad++;
            $display("FAIL mid_in_memrd act=%h exp=%h", act, e);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        total++;
        e = exp_vec(0, op, funct, zero, 1'b0, 1'b1);
        if (act !== e) begin
            bad++;
            $display("FAIL mid_async_reset act=%h exp=%h", act, e);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        e = exp_vec(0, op, funct, zero, 1'b0, 1'b0);
        if (act !== e) begin
            bad++;
            $display("FAIL mid_release_fetch act=%h exp=%h", act, e);
        end
        @(posedge clk); #1;
        exec_instr("after_mid", 6'b100011, 6'b000000, 1'b0, 0, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops [13];
        logic [5:0] fns [8];
        logic [5:0] o, f;
        ops = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
                6'b001101, 6'b001110, 6'b100011, 6'b100100, 6'b101011, 6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010,
                6'b000110, 6'b000000};
        for (int i = 0; i < 80; i++) begin
            o = ops[$urandom_range(0, 12)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            f = fns[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) f = 6'($urandom);
            exec_instr("random", o, f, 1'($urandom), -1, -1);
        end
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_imm_illegal();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_ctrl_ws.md
# multi_ctrl_ws

Parametrised multicycle MIPS control unit with memory wait-state handshake, bus timeout and an optional extended instruction set. It drives the same multicycle datapath as the existing controller: mux selects, register enables and ALU control. It adds a `mem_req`/`mem_ready` handshake so that instruction and data memories may take any number of cycles. It sits between the datapath and the memory system inside the `mips` top level.

## Interface
- `WAIT_W`, 4, width of the wait-state counter.
- `MAX_WAIT`, 15, stall cycles tolerated before a bus error; 0 disables the timeout; must be < 2**WAIT_W.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `op` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `memwrite` out 1: store.
- `pcen`, `irwrite`, `regwrite` out 1 each: register enables.
- `alusrca`, `iord`, `memtoreg`, `regdst`, `lbu` out 1 each: datapath selects.
- `alusrcb` out 3: 000 B, 001 const 4, 010 signimm, 011 signimm<<2, 100 zeroimm.
- `pcsrc` out 2: 00 aluresult, 01 aluout, 10 jump target.
- `alucontrol` out 4: 0010 add, 1010 sub, 0000 and, 0001 or, 0011 xor, 1011 slt, 0100 srlv.
- `illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode.
- `bus_err` out 1: sticky timeout flag.
- `state` out 5: debug view of the FSM state.

## Operation
- States are FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, ERROR 12.
- In each state, unlisted outputs are 0.
  - **FETCH:** `mem_req`=1; `alusrcb`=001; add.
    - `irwrite` = `pcen` = `mem_ready`.
    - Leave FETCH only when `mem_ready`=1.
  - **DECODE:** `alusrcb`=011; add.
  - **MEMADR:** `alusrca`=1; `alusrcb`=010; add.
  - **MEMRD:** `mem_req`=1; `iord`=1.
  - **MEMWR:** `mem_req`=1; `memwrite`=1; `iord`=1.
  - MEMRD and MEMWR hold until `mem_ready`.
  - **MEMWB:** `regwrite`=1; `memtoreg`=1.
  - **EXECUTE:** `alusrca`=1; `alusrcb`=000; ALU decoded from `funct`.
  - **ALUWB:** `regwrite`=1; `regdst`=1.
  - **BRANCH:** `alusrca`=1; sub; `pcsrc`=01.
    - BEQ: `pcen`=`zero`.
    - BNE: `pcen`=!`zero`.
  - **IEXEC:** `alusrca`=1.
    - ADDI: `alusrcb`=010, add.
    - ANDI/ORI/XORI: `alusrcb`=100, with and/or/xor respectively.
  - **IWB:** `regwrite`=1.
  - **JUMP:** `pcen`=1; `pcsrc`=10.
  - **ERROR:** `bus_err`=1. Absorbing until reset.
- DECODE transitions:
  - LW/LBU/SW go to MEMADR, then MEMRD (loads) or MEMWR (SW).
  - R-type goes to EXECUTE.
  - BEQ/BNE go to BRANCH.
  - ADDI/ANDI/ORI/XORI go to IEXEC.
  - J goes to JUMP.
  - Any other opcode goes to FETCH with `illegal`=1.
- Successor transitions:
  - MEMRD goes to MEMWB.
  - EXECUTE goes to ALUWB.
  - IEXEC goes to IWB.
  - MEMWB, MEMWR, ALUWB, IWB, BRANCH and JUMP go to FETCH.
- `lbu`=1 in MEMRD and MEMWB when `op`=100100.
- Funct decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 101010 slt, 000110 srlv.
  - Any other funct gives add (0010) and no write suppression.
- Wait counter:
  - Clears on every state change and on any cycle with `mem_ready`=1.
  - Increments in FETCH/MEMRD/MEMWR on each cycle with `mem_ready`=0.
  - When it equals `MAX_WAIT` (non-zero) and `mem_ready`=0, the next state is ERROR. The bus error therefore fires on the (`MAX_WAIT`+1)th consecutive not-ready cycle.
  - If `mem_ready` rises in the same cycle that the count hits `MAX_WAIT`, the normal transition wins.

## Timing
- `state`, `bus_err` and the wait counter are the only registers.
- All other outputs are combinational from `state`, `op`, `funct`, `zero` and `mem_ready`.
- While `reset` is high:
  - `state`=FETCH, counter 0, `bus_err`=0.
  - `pcen`, `irwrite`, `regwrite`, `memwrite`, `mem_req` and `illegal` are forced 0.
  - `alusrcb`=001, `alucontrol`=0010, all other outputs 0.
- Reset mid-access abandons the transfer; the first cycle after release is FETCH with `mem_req`=1.
- Zero-wait cycle counts per instruction: LW/LBU 5, SW 4, R-type 4, I-type ALU 4, BEQ/BNE 3, J 3.
- Each not-ready cycle in a memory state adds one cycle.
- `mem_ready` is sampled only while `mem_req`=1; it is ignored elsewhere.

## Configuration
- `MULTI_CTRL_EXT_EN`: when defined, BNE (000101), ANDI (001100), ORI (001101), XORI (001110), LBU (100100) and the xor/srlv functs are decoded.
- When undefined:
  - Those opcodes take the illegal path to FETCH, with the `illegal` pulse.
  - `lbu` is tied to 0.
  - xor/srlv functs decode as add.
  - `alusrcb` never takes 100.

## Test plan
- Reset release, `mem_ready`=1 constant, R-type add → states 0,1,6,7,0.
  - `regwrite`=1 and `regdst`=1 in ALUWB only.
  - `alucontrol`=0010 in EXECUTE.
- LW with `mem_ready` low for 3 cycles in MEMRD → MEMRD held 4 cycles, `iord`=1 throughout, MEMWB follows, 8 cycles total.
- `MAX_WAIT`=3, `mem_ready` stuck 0 in FETCH → ERROR entered after the 4th not-ready cycle.
  - `bus_err`=1 and held.
  - Deasserting `reset` returns to FETCH with `bus_err`=0.
- BNE with `zero`=0 → `pcen`=1, `pcsrc`=01 in BRANCH. BEQ with `zero`=0 → `pcen`=0.
- Opcode 111111 → `illegal` pulse in DECODE, next state FETCH, no `regwrite`.
- With `MULTI_CTRL_EXT_EN`: ORI → IEXEC `alusrcb`=100, `alucontrol`=0001. Without it: ORI → `illegal`.
